// File: rtl/onchip_ram_dual_pipelined.sv
// onchip_ram_dual_pipelined: true-dual-port byte-enabled RAM with two Avalon-MM slaves and fixed-latency reads
module onchip_ram_dual_pipelined #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 13,
  parameter int    DEPTH        = 8192,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "onchip_ram_dual_pipelined.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic                    a_chipselect,
  input  logic                    a_read,
  input  logic                    a_write,
  input  logic [DATA_WIDTH/8-1:0] a_byteenable,
  input  logic [DATA_WIDTH-1:0]   a_writedata,
  output logic [DATA_WIDTH-1:0]   a_readdata,
  output logic                    a_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic                    b_chipselect,
  input  logic                    b_read,
  input  logic                    b_write,
  input  logic [DATA_WIDTH/8-1:0] b_byteenable,
  input  logic [DATA_WIDTH-1:0]   b_writedata,
  output logic [DATA_WIDTH-1:0]   b_readdata,
  output logic                    b_readdatavalid
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  en;
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [NB-1:0]         be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic                  wr    [2];
  logic                  rd    [2];
  logic                  hit   [2];
  logic [DATA_WIDTH-1:0] pd    [2][READ_LATENCY];
  logic                  pv    [2][READ_LATENCY];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic                  rvalid[2];

  if ((READ_LATENCY != 1 && READ_LATENCY != 2) || DATA_WIDTH % 8 != 0) begin : g_bad
    $error("onchip_ram_dual_pipelined: READ_LATENCY must be 1 or 2 and DATA_WIDTH a multiple of 8");
  end

  assign en = clken & ~reset_req;

  always_comb begin
    addr  = '{a_address, b_address};
    be    = '{a_byteenable, b_byteenable};
    wdata = '{a_writedata, b_writedata};
    wr    = '{a_chipselect & a_write & en, b_chipselect & b_write & en};
    rd    = '{a_chipselect & a_read & ~a_write & en, b_chipselect & b_read & ~b_write & en};
    for (int p = 0; p < 2; p++) hit[p] = {1'b0, addr[p]} < LIM;
  end

  always_ff @(posedge clk)
    for (int i = 0; i < NB; i++) begin
      if (wr[1] && hit[1] && be[1][i] && !(wr[0] && be[0][i] && addr[0] == addr[1]))
        mem[addr[1][IW-1:0]][i*8 +: 8] <= wdata[1][i*8 +: 8];
      if (wr[0] && hit[0] && be[0][i])
        mem[addr[0][IW-1:0]][i*8 +: 8] <= wdata[0][i*8 +: 8];
    end

  always_ff @(posedge clk)
    for (int p = 0; p < 2; p++) begin
      if (!reset_n) begin
        for (int s = 0; s < READ_LATENCY; s++) pv[p][s] <= 1'b0;
        rvalid[p] <= 1'b0;
        rdata[p]  <= '0;
      end else if (en) begin
        pv[p][0] <= rd[p];
        pd[p][0] <= hit[p] ? mem[addr[p][IW-1:0]] : '0;
        for (int s = 1; s < READ_LATENCY; s++) begin
          pv[p][s] <= pv[p][s-1];
          pd[p][s] <= pd[p][s-1];
        end
        rvalid[p] <= pv[p][READ_LATENCY-1];
        if (pv[p][READ_LATENCY-1]) rdata[p] <= pd[p][READ_LATENCY-1];
      end else begin
        rvalid[p] <= 1'b0;
      end
    end

  assign a_readdata      = rdata[0];
  assign a_readdatavalid = rvalid[0];
  assign b_readdata      = rdata[1];
  assign b_readdatavalid = rvalid[1];
endmodule

// File: tb/tb_onchip_ram_dual_pipelined.sv
// tb_onchip_ram_dual_pipelined: directed table, corner sequences and random traffic against a queue-based model
module tb_onchip_ram_dual_pipelined;
  localparam int AW  = 5;
  localparam int DEP = 20;

  typedef struct {
    logic [1:0]  ao;
    logic [4:0]  aa;
    logic [31:0] awd;
    logic [3:0]  abe;
    logic [1:0]  bo;
    logic [4:0]  ba;
    logic [31:0] bwd;
    logic [3:0]  bbe;
    logic [1:0]  cp;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  logic clk = 0, rst_n = 0, clken = 1, rreq = 0;
  logic a_cs = 0, a_rd = 0, a_wr = 0, b_cs = 0, b_rd = 0, b_wr = 0;
  logic [3:0] a_be = 0, b_be = 0;
  logic [AW-1:0] a_ad = 0, b_ad = 0;
  logic [31:0] a_wd = 0, b_wd = 0;
  logic [31:0] ard [2], brd [2];
  logic av [2], bv [2];
  int checks = 0, errors = 0;

  logic [31:0] m [32];
  int ecnt = 0;
  int due_q [4][$];
  logic [31:0] dat_q [4][$];
  logic exp_v [4];
  logic [31:0] exp_d [4];
  vec_t tbl [$];

  always #5 clk = ~clk;

  onchip_ram_dual_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset_n(rst_n), .clken(clken), .reset_req(rreq),
    .a_address(a_ad), .a_chipselect(a_cs), .a_read(a_rd), .a_write(a_wr), .a_byteenable(a_be), .a_writedata(a_wd),
    .a_readdata(ard[0]), .a_readdatavalid(av[0]),
    .b_address(b_ad), .b_chipselect(b_cs), .b_read(b_rd), .b_write(b_wr), .b_byteenable(b_be), .b_writedata(b_wd),
    .b_readdata(brd[0]), .b_readdatavalid(bv[0]));

  onchip_ram_dual_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(2), .INIT_FILE("")) dut2 (
    .clk(clk), .reset_n(rst_n), .clken(clken), .reset_req(rreq),
    .a_address(a_ad), .a_chipselect(a_cs), .a_read(a_rd), .a_write(a_wr), .a_byteenable(a_be), .a_writedata(a_wd),
    .a_readdata(ard[1]), .a_readdatavalid(av[1]),
    .b_address(b_ad), .b_chipselect(b_cs), .b_read(b_rd), .b_write(b_wr), .b_byteenable(b_be), .b_writedata(b_wd),
    .b_readdata(brd[1]), .b_readdatavalid(bv[1]));

  function automatic vec_t mk(input logic [1:0] ao, input logic [4:0] aa, input logic [31:0] awd, input logic [3:0] abe,
                              input logic [1:0] bo, input logic [4:0] ba, input logic [31:0] bwd, input logic [3:0] bbe,
                              input logic [1:0] cp, input logic ev, input logic [31:0] ed);
    mk = '{ao, aa, awd, abe, bo, ba, bwd, bbe, cp, ev, ed};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic xchk(input string name, input logic v, input logic [31:0] d, input logic ev, input logic [31:0] ed);
    cmp({name, "_valid"}, {31'd0, v}, {31'd0, ev});
    if (ev) cmp({name, "_data"}, d, ed);
  endtask

  task automatic set_ops(input logic [1:0] ao, input logic [4:0] aa, input logic [31:0] awd, input logic [3:0] abe,
                         input logic [1:0] bo, input logic [4:0] ba, input logic [31:0] bwd, input logic [3:0] bbe);
    a_cs = |ao; a_rd = ao[0]; a_wr = ao[1]; a_ad = aa; a_wd = awd; a_be = abe;
    b_cs = |bo; b_rd = bo[0]; b_wr = bo[1]; b_ad = ba; b_wd = bwd; b_be = bbe;
  endtask

  task automatic model_edge();
    logic en, ra, rb, wa, wb;
    logic [31:0] da, db;
    en = clken & ~rreq;
    ra = a_cs & a_rd & ~a_wr & en;
    rb = b_cs & b_rd & ~b_wr & en;
    wa = a_cs & a_wr & en;
    wb = b_cs & b_wr & en;
    da = (int'(a_ad) < DEP) ? m[a_ad] : 32'd0;
    db = (int'(b_ad) < DEP) ? m[b_ad] : 32'd0;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        due_q[k].delete(); dat_q[k].delete(); exp_v[k] = 0; exp_d[k] = 0;
      end
    end else if (en) begin
      ecnt++;
      for (int k = 0; k < 4; k++) begin
        exp_v[k] = 0;
        if (due_q[k].size() > 0 && due_q[k][0] == ecnt) begin
          exp_v[k] = 1;
          exp_d[k] = dat_q[k].pop_front();
          void'(due_q[k].pop_front());
        end
      end
      for (int l = 0; l < 2; l++) begin
        if (ra) begin due_q[l].push_back(ecnt + l + 1); dat_q[l].push_back(da); end
        if (rb) begin due_q[2+l].push_back(ecnt + l + 1); dat_q[2+l].push_back(db); end
      end
    end else begin
      for (int k = 0; k < 4; k++) exp_v[k] = 0;
    end
    if (wb && int'(b_ad) < DEP)
      for (int i = 0; i < 4; i++) if (b_be[i]) m[b_ad][i*8 +: 8] = b_wd[i*8 +: 8];
    if (wa && int'(a_ad) < DEP)
      for (int i = 0; i < 4; i++) if (a_be[i]) m[a_ad][i*8 +: 8] = a_wd[i*8 +: 8];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      logic v;
      logic [31:0] d;
      v = (k < 2) ? av[k % 2] : bv[k % 2];
      d = (k < 2) ? ard[k % 2] : brd[k % 2];
      cmp($sformatf("model_%s_lat%0d_valid", k < 2 ? "a" : "b", k % 2 + 1), {31'd0, v}, {31'd0, exp_v[k]});
      cmp($sformatf("model_%s_lat%0d_data", k < 2 ? "a" : "b", k % 2 + 1), d, exp_d[k]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    xchk("reset_a1", av[0], ard[0], 0, 0);
    cmp("reset_a1_data", ard[0], 0);
    cmp("reset_b2_data", brd[1], 0);
    rst_n = 1;
    for (int i = 0; i < DEP; i++) begin
      set_ops(2, 5'(i), 0, 4'hF, 0, 0, 0, 0);
      step();
    end
    tbl.push_back(mk(2, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF));
    tbl.push_back(mk(2, 9, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 9, 32'h11223344, 4'h3, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 32'hFFFF3344));
    tbl.push_back(mk(2, 7, 32'hAAAAAAAA, 4'hC, 2, 7, 32'hBBBBBBBB, 4'h6, 0, 0, 0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hAAAABB00));
    tbl.push_back(mk(2, 3, 32'h77, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 3, 32'h55, 4'hF, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 2, 1, 32'h77));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 32'h55));
    tbl.push_back(mk(2, 25, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 25, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 2, 32'h99, 4'hF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 32'h99));
    tbl.push_back(mk(2, 2, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h99));
    foreach (tbl[i]) begin
      set_ops(tbl[i].ao, tbl[i].aa, tbl[i].awd, tbl[i].abe, tbl[i].bo, tbl[i].ba, tbl[i].bwd, tbl[i].bbe);
      step();
      if (tbl[i].cp == 1) xchk($sformatf("vec%0d_a", i), av[0], ard[0], tbl[i].ev, tbl[i].ed);
      if (tbl[i].cp == 2) xchk($sformatf("vec%0d_b", i), bv[0], brd[0], tbl[i].ev, tbl[i].ed);
    end
    for (int i = 0; i < 3; i++) begin
      set_ops(2, 5'(i), 32'h10 + i, 4'hF, 0, 0, 0, 0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      set_ops(0, 0, 0, 0, 1, 5'(i), 0, 0);
      step();
    end
    xchk("stall_b2_first", bv[1], brd[1], 1, 32'h10);
    clken = 0;
    set_ops(0, 0, 0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      xchk("stall_b2_held", bv[1], brd[1], 0, 0);
      cmp("stall_b2_hold_data", brd[1], 32'h10);
    end
    clken = 1;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    xchk("resume_b2_second", bv[1], brd[1], 1, 32'h11);
    step();
    xchk("resume_b2_third", bv[1], brd[1], 1, 32'h12);
    step();
    xchk("resume_b2_done", bv[1], brd[1], 0, 0);
    set_ops(2, 4, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
    step();
    set_ops(1, 4, 0, 0, 0, 0, 0, 0);
    step();
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    step();
    xchk("flush_a1", av[0], ard[0], 0, 0);
    cmp("flush_a1_data", ard[0], 0);
    cmp("flush_a2_data", ard[1], 0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      xchk("flush_a1_quiet", av[0], ard[0], 0, 0);
      xchk("flush_a2_quiet", av[1], ard[1], 0, 0);
    end
    set_ops(1, 4, 0, 0, 0, 0, 0, 0);
    step();
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    xchk("retain_a1", av[0], ard[0], 1, 32'hCAFEF00D);
    step();
    xchk("retain_a2", av[1], ard[1], 1, 32'hCAFEF00D);
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      clken = ($urandom_range(0, 9) != 0);
      rreq  = ($urandom_range(0, 19) == 0);
      set_ops(2'($urandom_range(0, 3)), 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 23) : $urandom_range(0, 5)),
              $urandom, 4'($urandom), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 23) : $urandom_range(0, 5)), $urandom, 4'($urandom));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
